// File: rtl/op_loader_pkg.sv
// Shared types and defaults for the operand loader and its pin synchronizer.
package op_loader_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a one-cycle rising-edge pulse.
module pin_sync_edge
  import op_loader_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to ones so a pin already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/op_loader.sv
// Captures operand A then operand B from a strobed pin bus and presents the pair
// downstream with a valid/ready handshake.
module op_loader
  import op_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_strb,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       state_dbg,
  output logic             overrun
);

  // Handshake: a pair transfers on a rising edge where op_valid and op_ready are
  // both 1; op_valid never drops and op_a/op_b never change until that transfer.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;
  logic             overrun_q, overrun_d;
  logic             strb_edge;

  pin_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strb_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (load_strb),
    .edge_pulse(strb_edge)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    overrun_d  = overrun_q;
    case (state_q)
      LOAD_A: begin
        if (strb_edge) begin
          op_a_d  = data_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (strb_edge) begin
          op_b_d     = data_in;
          op_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          // A strobe coinciding with the transfer starts the next pair.
          if (strb_edge) begin
            op_a_d  = data_in;
            state_d = LOAD_B;
          end else begin
            state_d = LOAD_A;
          end
        end else if (strb_edge) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: doc/op_loader.md
Name: op_loader

Overview:
- Operand staging block directly upstream of the 8-bit two-operand logic stage (the `a`/`b`/`Y` core) in the tt_um top level.
- Pins supply a single byte bus plus an asynchronous load strobe.
- Two successive strobes capture operand A, then operand B, into registers.
- The block then presents both operands with a valid/ready handshake, so the downstream stage sees stable, synchronized operands.

Parameters:
- WIDTH, 8, operand width in bits. Matches the `ui_in` bus.
- SYNC_STAGES, 2, number of synchronizer flops on `load_strb`. Must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  WIDTH  operand byte from pins. Asynchronous; must be stable from the strobe rising edge until capture.
- load_strb  in  1  asynchronous load strobe from a pin. Its rising edge requests a capture.
- op_a  out  WIDTH  operand A to the downstream stage.
- op_b  out  WIDTH  operand B to the downstream stage.
- op_valid  out  1  op_a/op_b form a complete pair.
- op_ready  in  1  downstream accepts the pair.
- state_dbg  out  2  FSM state encoding (0=LOAD_A, 1=LOAD_B, 2=PRESENT).
- overrun  out  1  sticky flag: a strobe edge arrived while a pair was pending.

Behaviour:
- Reset (rst_n low at a rising clk edge), state after the edge:
  - op_a=0, op_b=0, op_valid=0, overrun=0, state=LOAD_A.
  - Synchronizer chain and previous-value flop are set to all ones. A strobe held high through reset release therefore produces no edge.
- Synchronizer and edge detect:
  - `load_strb` passes through SYNC_STAGES flops.
  - edge = sync_out & ~prev.
  - A strobe first sampled high at edge k causes its capture at edge k+SYNC_STAGES.
  - A strobe must stay high for at least one sampling edge to be seen.
- FSM transitions (all registered):
  - LOAD_A, on edge: op_a <= data_in; go to LOAD_B.
  - LOAD_B, on edge: op_b <= data_in; op_valid <= 1; go to PRESENT.
  - PRESENT: op_valid held at 1; op_a/op_b held stable.
    - When op_ready=1 at a rising edge: op_valid <= 0; go to LOAD_A.
    - While op_ready=0, any strobe edge is ignored (no register change) and sets overrun=1.
- Simultaneous op_ready=1 and strobe edge in PRESENT:
  - The handshake completes.
  - The edge is consumed as a new operand A: op_a <= data_in; go to LOAD_B; op_valid <= 0.
  - overrun is not set.
- Pair timing:
  - op_valid rises at the same edge that captures op_b, so latency from the B capture to valid is 0 extra cycles.
  - The minimum pair period is 1 cycle of valid when op_ready is tied high.
- op_ready is ignored outside PRESENT.
- op_a is visible while in LOAD_B, but downstream qualifies it only by op_valid.
- overrun clears only on reset.
- Reset mid-operation: any state returns to the reset values at that edge. A partially loaded pair is discarded.
- Illegal state encoding (3) goes to LOAD_A on the next edge.
- All outputs are driven from registers. There is no combinational path from inputs to outputs.

Decomposition:
- Package op_loader_pkg:
  - state enum (LOAD_A=2'd0, LOAD_B=2'd1, PRESENT=2'd2).
  - Default WIDTH and SYNC_STAGES constants.
- Sub-module pin_sync_edge:
  - Parameterized SYNC_STAGES synchronizer with reset-to-one and a registered prev flop.
  - Outputs a one-cycle rising-edge pulse.
  - Reusable for other pin strobes in the top level.

Test Plan:
- Basic load, op_ready=1: strobe with data_in=0x3C, then strobe with 0xA5. Expect op_a=0x3C, op_b=0xA5, op_valid high exactly 1 cycle, state_dbg back to 0, overrun=0.
- Latency: strobe first sampled at edge k. With SYNC_STAGES=2, op_a updates at edge k+2; with SYNC_STAGES=3, at edge k+3.
- Backpressure: op_ready=0 after the pair 0x0F/0xF0 loads. op_valid=1 and operands stay stable for 10 cycles. Raise op_ready; op_valid=0 one edge later and state_dbg=0.
- Overrun: with the pair pending and op_ready=0, pulse the strobe with data 0x77. Operands stay 0x0F/0xF0, overrun=1 and stays set after the handshake completes.
- Simultaneous: in PRESENT, align the strobe edge with op_ready=1 and data 0x11. Handshake completes, op_a=0x11, state_dbg=1, overrun=0.
- Reset mid-operation: after loading A=0x55 (state_dbg=1), drive rst_n low for 1 cycle while holding the strobe high through release. Expect all outputs 0, state_dbg=0, no capture until the strobe falls and rises again.
